// File: rtl/axis_accel_sequencer_pkg.sv
// ============================================================================
// axis_accel_sequencer_pkg : shared state encoding and width defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package axis_accel_sequencer_pkg;

    localparam int ITR_W_DEF  = 16;
    localparam int BEAT_W_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WGT   = 3'd1,
        ST_PIX   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_accel_sequencer_gate.sv
// ============================================================================
// axis_gate : AND-gates one AXIS valid/ready pair; last passes through
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_gate (
    input  logic en,
    input  logic s_valid,
    output logic s_ready,
    input  logic s_last,
    output logic m_valid,
    input  logic m_ready,
    output logic m_last,
    output logic fire
);

    assign m_valid = s_valid & en;
    assign s_ready = m_ready & en;
    assign m_last  = s_last;
    assign fire    = s_valid & m_ready & en;

endmodule

`default_nettype wire

// File: rtl/axis_accel_sequencer.sv
// ============================================================================
// axis_accel_sequencer : layer controller ordering W/P streams, counts drain
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_accel_sequencer
    import axis_accel_sequencer_pkg::*;
#(
    parameter int ITR_W  = ITR_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_desc_valid,
    output logic              s_desc_ready,
    input  logic [ITR_W-1:0]  s_desc_itr,
    input  logic [BEAT_W-1:0] s_desc_wbeats,
    input  logic [BEAT_W-1:0] s_desc_pbeats,
    input  logic              s_wgt_valid,
    output logic              s_wgt_ready,
    input  logic              s_wgt_last,
    output logic              m_wgt_valid,
    input  logic              m_wgt_ready,
    output logic              m_wgt_last,
    input  logic              s_pix_valid,
    output logic              s_pix_ready,
    input  logic              s_pix_last,
    output logic              m_pix_valid,
    input  logic              m_pix_ready,
    output logic              m_pix_last,
    input  logic              out_valid,
    input  logic              out_ready,
    input  logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err_last
);

    localparam logic [ITR_W-1:0]  ITR_ONE  = ITR_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    seq_state_t        state, state_nx;
    logic [ITR_W-1:0]  itr_cnt, itr_nx, out_cnt, out_nx;
    logic [BEAT_W-1:0] w_cnt, w_nx, p_cnt, p_nx;
    logic [BEAT_W-1:0] wbeats, wb_nx, pbeats, pb_nx;
    logic              err_nx, end_iter;
    logic              en_wgt, en_pix, w_fire, p_fire, out_fire;

    // Gate enables come from registered state/config only; pixel gate stays
    // shut for zero-beat pixel phases so no stray beat can slip through.
    assign en_wgt       = (state == ST_WGT);
    assign en_pix       = (state == ST_PIX) && (pbeats != '0);
    assign s_desc_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign out_fire     = out_valid & out_ready & out_last;

    axis_gate u_gate_wgt (
        .en(en_wgt), .s_valid(s_wgt_valid), .s_ready(s_wgt_ready), .s_last(s_wgt_last),
        .m_valid(m_wgt_valid), .m_ready(m_wgt_ready), .m_last(m_wgt_last), .fire(w_fire)
    );

    axis_gate u_gate_pix (
        .en(en_pix), .s_valid(s_pix_valid), .s_ready(s_pix_ready), .s_last(s_pix_last),
        .m_valid(m_pix_valid), .m_ready(m_pix_ready), .m_last(m_pix_last), .fire(p_fire)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            itr_cnt  <= '0;
            out_cnt  <= '0;
            w_cnt    <= '0;
            p_cnt    <= '0;
            wbeats   <= '0;
            pbeats   <= '0;
            err_last <= 1'b0;
        end else begin
            state    <= state_nx;
            itr_cnt  <= itr_nx;
            out_cnt  <= out_nx;
            w_cnt    <= w_nx;
            p_cnt    <= p_nx;
            wbeats   <= wb_nx;
            pbeats   <= pb_nx;
            err_last <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        itr_nx   = itr_cnt;
        out_nx   = out_cnt;
        w_nx     = w_cnt;
        p_nx     = p_cnt;
        wb_nx    = wbeats;
        pb_nx    = pbeats;
        err_nx   = err_last;
        end_iter = 1'b0;

        if ((state != ST_IDLE) && out_fire) begin
            if (out_cnt == '0) err_nx = 1'b1;
            else               out_nx = out_cnt - ITR_ONE;
        end
        if (w_fire && (s_wgt_last != (w_cnt == BEAT_ONE))) err_nx = 1'b1;
        if (p_fire && (s_pix_last != (p_cnt == BEAT_ONE))) err_nx = 1'b1;

        case (state)
            ST_IDLE: begin
                if (s_desc_valid) begin
                    itr_nx = s_desc_itr;
                    out_nx = s_desc_itr;
                    w_nx   = s_desc_wbeats;
                    p_nx   = s_desc_pbeats;
                    wb_nx  = s_desc_wbeats;
                    pb_nx  = s_desc_pbeats;
                    err_nx = 1'b0;
                    // Empty layers still pass through DRAIN so done lands two cycles after accept.
                    if (s_desc_itr == '0)         state_nx = ST_DRAIN;
                    else if (s_desc_wbeats == '0) state_nx = ST_PIX;
                    else                          state_nx = ST_WGT;
                end
            end
            ST_WGT: begin
                if (w_fire) begin
                    if (w_cnt != '0) w_nx = w_cnt - BEAT_ONE;
                    if (w_cnt == BEAT_ONE) begin
                        if (pbeats == '0) begin
                            end_iter = 1'b1;
                        end else begin
                            state_nx = ST_PIX;
                            p_nx     = pbeats;
                        end
                    end
                end
            end
            ST_PIX: begin
                if (pbeats == '0) begin
                    end_iter = 1'b1;
                end else if (p_fire) begin
                    if (p_cnt != '0) p_nx = p_cnt - BEAT_ONE;
                    if (p_cnt == BEAT_ONE) end_iter = 1'b1;
                end
            end
            ST_DRAIN: if (out_cnt == '0) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase

        if (end_iter) begin
            if (itr_cnt != '0) itr_nx = itr_cnt - ITR_ONE;
            if (itr_cnt <= ITR_ONE) begin
                state_nx = ST_DRAIN;
            end else begin
                w_nx     = wbeats;
                p_nx     = pbeats;
                state_nx = (wbeats == '0) ? ST_PIX : ST_WGT;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_accel_sequencer.sv
// ============================================================================
// tb_axis_accel_sequencer : scoreboard bench for beat order, drain and done
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axis_accel_sequencer;

    localparam int ITR_W  = 16;
    localparam int BEAT_W = 20;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_desc_valid = 1'b0;
    logic              s_desc_ready;
    logic [ITR_W-1:0]  s_desc_itr = '0;
    logic [BEAT_W-1:0] s_desc_wbeats = '0;
    logic [BEAT_W-1:0] s_desc_pbeats = '0;
    logic              s_wgt_valid = 1'b0, s_wgt_ready, s_wgt_last = 1'b0;
    logic              m_wgt_valid, m_wgt_ready = 1'b1, m_wgt_last;
    logic              s_pix_valid = 1'b0, s_pix_ready, s_pix_last = 1'b0;
    logic              m_pix_valid, m_pix_ready = 1'b1, m_pix_last;
    logic              out_valid = 1'b0, out_ready = 1'b1, out_last = 1'b0;
    logic              busy, done, err_last;

    int tests = 0, fails = 0;
    int done_cnt = 0, wgt_seen = 0, pix_seen = 0;
    int sb[$];          // expected beat order: 1 = weight, 2 = pixel
    bit bp = 1'b0;

    axis_accel_sequencer #(.ITR_W(ITR_W), .BEAT_W(BEAT_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
        .s_desc_itr(s_desc_itr), .s_desc_wbeats(s_desc_wbeats), .s_desc_pbeats(s_desc_pbeats),
        .s_wgt_valid(s_wgt_valid), .s_wgt_ready(s_wgt_ready), .s_wgt_last(s_wgt_last),
        .m_wgt_valid(m_wgt_valid), .m_wgt_ready(m_wgt_ready), .m_wgt_last(m_wgt_last),
        .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready), .s_pix_last(s_pix_last),
        .m_pix_valid(m_pix_valid), .m_pix_ready(m_pix_ready), .m_pix_last(m_pix_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .err_last(err_last)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream/tap readiness, optionally randomised.
    initial forever begin
        @(posedge aclk); #1;
        m_wgt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: a gate may only be open when the next expected beat is its own.
    always @(negedge aclk) begin
        int tok;
        if (aresetn) begin
            if (m_wgt_valid || s_wgt_ready)
                check("wgt_gate_open", (sb.size() > 0) ? int'(sb[0] == 1) : 0, 1);
            if (m_pix_valid || s_pix_ready)
                check("pix_gate_open", (sb.size() > 0) ? int'(sb[0] == 2) : 0, 1);
            if (m_wgt_valid && m_wgt_ready) begin
                wgt_seen++;
                tok = (sb.size() > 0) ? sb.pop_front() : 0;
                check("beat_order_wgt", tok, 1);
                check("wgt_last_pass", m_wgt_last, s_wgt_last);
            end
            if (m_pix_valid && m_pix_ready) begin
                pix_seen++;
                tok = (sb.size() > 0) ? sb.pop_front() : 0;
                check("beat_order_pix", tok, 2);
                check("pix_last_pass", m_pix_last, s_pix_last);
            end
            if (done) done_cnt++;
        end
    end

    task automatic send_desc(input int itr, input int wb, input int pb);
        int n;
        s_desc_valid = 1'b1;
        s_desc_itr = ITR_W'(itr); s_desc_wbeats = BEAT_W'(wb); s_desc_pbeats = BEAT_W'(pb);
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_desc_ready && n < 2000);
        if (!s_desc_ready) check("desc_timeout", 1, 0);
        @(posedge aclk); #1;
        s_desc_valid = 1'b0;
    endtask

    task automatic wgt_stream(input int itr, input int wb, input int err_beat, input bit rnd);
        for (int i = 0; i < itr; i++) begin
            for (int b = 0; b < wb; b++) begin
                int n;
                if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                s_wgt_valid = 1'b1;
                s_wgt_last  = (err_beat >= 0) ? (b == err_beat) : (b == wb - 1);
                n = 0;
                do begin @(negedge aclk); n++; end while (!s_wgt_ready && n < 2000);
                if (!s_wgt_ready) check("wgt_timeout", 1, 0);
                @(posedge aclk); #1;
                s_wgt_valid = 1'b0;
                s_wgt_last  = 1'b0;
            end
        end
    endtask

    task automatic pix_stream(input int itr, input int pb, input int max_beats, input bit rnd);
        int sent = 0;
        for (int i = 0; i < itr; i++) begin
            for (int b = 0; b < pb; b++) begin
                int n;
                if (sent < max_beats) begin
                    if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                    s_pix_valid = 1'b1;
                    s_pix_last  = (b == pb - 1);
                    n = 0;
                    do begin @(negedge aclk); n++; end while (!s_pix_ready && n < 2000);
                    if (!s_pix_ready) check("pix_timeout", 1, 0);
                    @(posedge aclk); #1;
                    s_pix_valid = 1'b0;
                    s_pix_last  = 1'b0;
                    sent++;
                end
            end
        end
    endtask

    task automatic out_stream(input int cnt, input bit rnd);
        for (int k = 0; k < cnt; k++) begin
            int n;
            if (rnd) repeat ($urandom_range(0, 4)) begin @(posedge aclk); #1; end
            out_valid = 1'b1;
            out_last  = 1'b1;
            n = 0;
            do begin @(negedge aclk); n++; end while (!out_ready && n < 2000);
            @(posedge aclk); #1;
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
    endtask

    task automatic run_layer(input int itr, input int wb, input int pb, input int err_beat,
                             input bit rnd, input int exp_err);
        int d0, n;
        for (int i = 0; i < itr; i++) begin
            for (int b = 0; b < wb; b++) sb.push_back(1);
            for (int b = 0; b < pb; b++) sb.push_back(2);
        end
        d0 = done_cnt;
        send_desc(itr, wb, pb);
        fork
            wgt_stream(itr, wb, err_beat, rnd);
            pix_stream(itr, pb, itr * pb, rnd);
            out_stream(itr, rnd);
        join
        n = 0;
        while (done_cnt == d0 && n < 300) begin @(posedge aclk); #1; n++; end
        repeat (3) begin @(posedge aclk); #1; end
        check("done_once", done_cnt - d0, 1);
        check("busy_after_done", busy, 0);
        check("err_last", err_last, exp_err);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int d0, ew, ep, w0, p0, dn0;

        // Reset state
        repeat (3) begin @(posedge aclk); #1; end
        check("rst_desc_ready", s_desc_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_last", err_last, 0);
        check("rst_wgt_gate", s_wgt_ready, 0);
        check("rst_pix_gate", s_pix_ready, 0);
        aresetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end

        // Two iterations, full throughput; then pixels offered early
        run_layer(2, 3, 4, -1, 1'b0, 0);
        run_layer(1, 3, 2, -1, 1'b0, 0);

        // Early tlast on weight beat 2 of 3
        run_layer(1, 3, 2, 1, 1'b0, 1);
        repeat (2) begin @(posedge aclk); #1; end
        check("err_sticky", err_last, 1);

        // Empty layer: done two cycles after accept, gates stay shut
        d0 = done_cnt;
        s_wgt_valid = 1'b1;
        s_pix_valid = 1'b1;
        send_desc(0, 3, 3);
        check("err_clear_on_accept", err_last, 0);
        @(negedge aclk); check("itr0_done_c1", done, 0);
        @(negedge aclk); check("itr0_done_c2", done, 1);
        @(negedge aclk); check("itr0_done_c3", done, 0);
        check("itr0_busy", busy, 0);
        @(posedge aclk); #1;
        s_wgt_valid = 1'b0;
        s_pix_valid = 1'b0;
        check("itr0_done_once", done_cnt - d0, 1);

        // Pixel-only layer and all-zero-beat iterations
        w0 = wgt_seen;
        run_layer(1, 0, 5, -1, 1'b0, 0);
        check("pix_only_no_wgt", wgt_seen - w0, 0);
        run_layer(3, 0, 0, -1, 1'b0, 0);

        // Random layers with backpressure everywhere
        bp = 1'b1;
        ew = 0; ep = 0; w0 = wgt_seen; p0 = pix_seen; dn0 = done_cnt;
        for (int l = 0; l < 50; l++) begin
            int itr, wb, pb;
            itr = $urandom_range(1, 3);
            wb  = $urandom_range(0, 3);
            pb  = $urandom_range(0, 3);
            ew += itr * wb;
            ep += itr * pb;
            run_layer(itr, wb, pb, -1, 1'b1, 0);
        end
        check("rand_wgt_beats", wgt_seen - w0, ew);
        check("rand_pix_beats", pix_seen - p0, ep);
        check("rand_done_count", done_cnt - dn0, 50);
        bp = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end

        // Reset in the middle of the pixel phase with two pixel beats left
        sb.push_back(1); sb.push_back(1); sb.push_back(2); sb.push_back(2);
        d0 = done_cnt;
        send_desc(1, 2, 4);
        fork
            wgt_stream(1, 2, -1, 1'b0);
            pix_stream(1, 4, 2, 1'b0);
        join
        s_pix_valid = 1'b1;
        s_wgt_valid = 1'b1;
        #1;
        check("pre_rst_pix_open", m_pix_valid, 1);
        aresetn = 1'b0;
        #1;
        check("rst_mid_pix_valid", m_pix_valid, 0);
        check("rst_mid_pix_ready", s_pix_ready, 0);
        check("rst_mid_wgt_valid", m_wgt_valid, 0);
        check("rst_mid_busy", busy, 0);
        repeat (4) begin @(posedge aclk); #1; end
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_sb", sb.size(), 0);
        s_pix_valid = 1'b0;
        s_wgt_valid = 1'b0;
        aresetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        run_layer(2, 2, 3, -1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
